// File: rtl/func_sweep_ctrl.sv
// Exhaustive sweep sequencer for a combinational W-in/OW-out function unit, checked against a golden copy.
// Optional build macro FUNC_SWEEP_MISR_EN adds a 16-bit MISR signature output 'sig'.
module func_sweep_ctrl #(
  parameter int W             = 4,
  parameter int OW            = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [W-1:0]  x_out,
  input  logic [OW-1:0] y_dut,
  input  logic [OW-1:0] y_gold,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W:0]    err_cnt,
  output logic [W-1:0]  first_err_idx,
  output logic          first_err_valid
`ifdef FUNC_SWEEP_MISR_EN
  ,
  output logic [15:0]   sig
`endif
);

  localparam logic [W-1:0] LAST_IDX    = {W{1'b1}};
  localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   x_q, x_d;
  logic [W:0]     err_q, err_d;
  logic [W-1:0]   fidx_q, fidx_d;
  logic           fval_q, fval_d;
  logic           pass_q, pass_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           mismatch_s;

`ifdef FUNC_SWEEP_MISR_EN
  logic [15:0]    sig_q, sig_d;

  // Galois shift for x^16+x^14+x^13+x^11+1, then fold the observed output into the low bits.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [OW-1:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0} ^ (s[15] ? 16'h6801 : 16'h0000);
    n[OW-1:0] = n[OW-1:0] ^ d;
    return n;
  endfunction

  assign sig = sig_q;
`endif

  assign mismatch_s      = (y_dut != y_gold);
  assign x_out           = x_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fval_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= 4'd0;
      x_q     <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fval_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FUNC_SWEEP_MISR_EN
      sig_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FUNC_SWEEP_MISR_EN
      sig_q   <= sig_d;
`endif
    end
  end

  // x_out is loaded on the edge entering DRIVE so it is stable for the whole vector slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fval_d  = fval_q;
    pass_d  = pass_q;
`ifdef FUNC_SWEEP_MISR_EN
    sig_d   = sig_q;
`endif
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        if (start && !abort) begin
          idx_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fval_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = S_DRIVE;
`ifdef FUNC_SWEEP_MISR_EN
          sig_d   = 16'hFFFF;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        cnt_d = 4'd0;
        if (abort) begin
          x_d     = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          x_d     = '0;
          state_d = S_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        // Result of this vector is recorded even when abort arrives in the same cycle.
        if (mismatch_s) begin
          err_d = err_q + {{W{1'b0}}, 1'b1};
          if (!fval_q) begin
            fidx_d = idx_q;
            fval_d = 1'b1;
          end else begin
            fval_d = 1'b1;
          end
        end else begin
          err_d = err_q;
        end
`ifdef FUNC_SWEEP_MISR_EN
        sig_d = misr_step(sig_q, y_dut);
`endif
        if (abort) begin
          x_d     = '0;
          state_d = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + {{(W-1){1'b0}}, 1'b1};
          x_d     = idx_q + {{(W-1){1'b0}}, 1'b1};
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        pass_d  = (err_q == '0);
        x_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        x_d     = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: table of full sweeps on two settle settings plus abort/reset/start-hold sequences.
module tb_func_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       abort = 1'b0;
  int         mode = 0;
  int         cur_sel = 0;

  logic [3:0] x1, x2, y_dut1, y_gold1, y_dut2, y_gold2;
  logic [3:0] y_dly = 4'd0;
  logic       busy1, done1, pass1, fval1, busy2, done2, pass2, fval2;
  logic [4:0] err1, err2;
  logic [3:0] fidx1, fidx2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] fn(input logic [3:0] x);
    return {x[0] ^ x[3], x[1] & x[2], ~x[2], x[3] | x[0]};
  endfunction

  function automatic logic [3:0] gmask(input int md, input logic [3:0] x);
    if (md == 1) return ((x == 4'd5) || (x == 4'd9)) ? 4'b0001 : 4'b0000;
    else if (md == 2) return 4'b1111;
    else return 4'b0000;
  endfunction

  assign y_dut1  = fn(x1);
  assign y_gold1 = fn(x1) ^ gmask(mode, x1);
  // Unit 2's output lags its input by a cycle, so it is only correct from WAIT onward.
  always @(posedge clk) y_dly <= fn(x2);
  assign y_dut2  = y_dly;
  assign y_gold2 = fn(x2) ^ gmask(mode, x2);

  func_sweep_ctrl #(.W(4), .OW(4), .SETTLE_CYCLES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .x_out(x1),
    .y_dut(y_dut1), .y_gold(y_gold1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_idx(fidx1), .first_err_valid(fval1));

  func_sweep_ctrl #(.W(4), .OW(4), .SETTLE_CYCLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .x_out(x2),
    .y_dut(y_dut2), .y_gold(y_gold2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_err_idx(fidx2), .first_err_valid(fval2));

  logic [3:0] xm, fim;
  logic [4:0] em;
  logic       bm, dm, pm, fvm;
  always_comb begin
    xm  = (cur_sel != 0) ? x2 : x1;
    fim = (cur_sel != 0) ? fidx2 : fidx1;
    em  = (cur_sel != 0) ? err2 : err1;
    bm  = (cur_sel != 0) ? busy2 : busy1;
    dm  = (cur_sel != 0) ? done2 : done1;
    pm  = (cur_sel != 0) ? pass2 : pass1;
    fvm = (cur_sel != 0) ? fval2 : fval1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_results(input int e, input int fi, input int fv, input int p);
    check("busy_idle", int'(bm), 0);
    check("done_idle", int'(dm), 0);
    check("x_idle", int'(xm), 0);
    check("err_cnt", int'(em), e);
    check("first_err_idx", int'(fim), fi);
    check("first_err_valid", int'(fvm), fv);
    check("pass", int'(pm), p);
  endtask

  // Launches a sweep and follows x_out cycle by cycle until done; done_at is the cycle index after the accepting edge.
  task automatic run_sweep(input int sel, input int md, input bit hold_start, output int done_at);
    int per;
    per = (sel != 0) ? 3 : 4;
    cur_sel = sel;
    mode = md;
    done_at = -1;
    @(negedge clk);
    if (sel != 0) start2 = 1'b1; else start1 = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (!hold_start) begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      if (c < 16 * per) begin
        check("x_seq", int'(xm), c / per);
        check("busy_run", int'(bm), 1);
      end
      if (dm) begin
        done_at = c;
        break;
      end
    end
    if (done_at < 0) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    int sel; int md; int err; int fidx; int fval; int pss; int dedge;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int dat;
    int dcount;
    tbl[0] = '{0, 0, 0,  0, 0, 1, 64};
    tbl[1] = '{0, 1, 2,  5, 1, 0, 64};
    tbl[2] = '{0, 2, 16, 0, 1, 0, 64};
    tbl[3] = '{1, 0, 0,  0, 0, 1, 48};
    tbl[4] = '{1, 1, 2,  5, 1, 0, 48};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      cur_sel = s;
      #0;
      check_idle_results(0, 0, 0, 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i].sel, tbl[i].md, 1'b0, dat);
      check("done_edge", dat, tbl[i].dedge);
      @(negedge clk);
      check_idle_results(tbl[i].err, tbl[i].fidx, tbl[i].fval, tbl[i].pss);
    end

    // abort during vector 5: partial count kept, no done, restart accepted
    cur_sel = 0; mode = 2;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy1), 0);
    check("abort_x", int'(x1), 0);
    check("abort_err", int'(err1), 5);
    check("abort_fidx", int'(fidx1), 0);
    check("abort_fval", int'(fval1), 1);
    dcount = 0;
    repeat (70) begin
      @(negedge clk);
      if (done1) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_pass", int'(pass1), 0);
    check("abort_err_hold", int'(err1), 5);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    check("restart_busy", int'(busy1), 1);
    check("restart_err", int'(err1), 0);
    check("restart_fval", int'(fval1), 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;

    // pass=1 first, then asynchronous reset in the middle of a WAIT
    run_sweep(0, 0, 1'b0, dat);
    @(negedge clk);
    check("pre_reset_pass", int'(pass1), 1);
    mode = 2;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_reset_err", int'(err1), 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_x", int'(x1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_err", int'(err1), 0);
    check("rst_fval", int'(fval1), 0);
    check("rst_pass", int'(pass1), 0);
    check("rst_done", int'(done1), 0);
    @(negedge clk); rst_n = 1'b1;

    // start held through the sweep and the DONE cycle
    run_sweep(0, 0, 1'b1, dat);
    check("hold_done_edge", dat, 64);
    @(negedge clk);
    check("hold_idle_busy", int'(busy1), 0);
    check("hold_pass", int'(pass1), 1);
    @(negedge clk);
    check("hold_reaccept_busy", int'(busy1), 1);
    check("hold_reaccept_x", int'(x1), 0);
    start1 = 1'b0;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
